// File: rtl/fft_buf_pkg.sv
// fft_buf_pkg: shared defaults, write-FSM encoding and magnitude scaling for the spectrum frame buffer.
package fft_buf_pkg;
    localparam int DEF_POINTS = 256;
    localparam int DEF_MAG_W  = 16;
    localparam int DEF_SHIFT  = 8;

    typedef enum logic [1:0] {IDLE, FILL, DROP} wr_state_t;

    function automatic logic [7:0] scale_sat(input logic [31:0] mag, input int sh);
        logic [31:0] q;
        q = mag >> sh;
        return (q > 32'd255) ? 8'hFF : q[7:0];
    endfunction
endpackage

// File: rtl/spectrum_dpram.sv
// spectrum_dpram: simple dual-port 8-bit RAM, one write port and one registered read port.
module spectrum_dpram #(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk)
        if (we) r_mem[waddr] <= wdata;

    // Only the output register is reset; the array itself stays uninitialised.
    always_ff @(posedge clk or posedge rst)
        if (rst) rdata <= 8'h00;
        else if (re) rdata <= r_mem[raddr];
endmodule

// File: rtl/fft_spectrum_buf.sv
// fft_spectrum_buf: ping-pong frame buffer between the FFT magnitude stream and the spectrum display,
// swapping banks only on display vsync so a frame is never torn.
module fft_spectrum_buf
    import fft_buf_pkg::*;
#(
    parameter int POINTS = DEF_POINTS,
    parameter int MAG_W  = DEF_MAG_W,
    parameter int SHIFT  = DEF_SHIFT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fft_valid,
    input  logic             fft_last,
    input  logic [MAG_W-1:0] fft_mag,
    input  logic             data_req,
    input  logic             fft_point_done,
    input  logic             out_vsync,
    output logic [7:0]       fft_point_cnt,
    output logic [7:0]       fft_data,
    output logic             frame_pending,
    output logic             frame_drop,
    output logic             short_err
);
    localparam int         AW       = $clog2(POINTS);
    localparam logic [8:0] NPTS     = 9'(POINTS);
    localparam logic [8:0] LAST_IDX = 9'(POINTS - 1);
    localparam logic [7:0] LAST_PTR = 8'(POINTS - 1);

    wr_state_t   r_state, w_state_n;
    logic [8:0]  r_wr_idx, w_idx_n;
    logic        r_wr_bank, r_rd_bank, r_pending, r_vs, r_drop, r_short;
    logic [7:0]  r_rd_ptr;
    logic        w_we, w_complete, w_short, w_drop, w_vs_edge, w_swap;
    logic [7:0]  w_wdata;

    assign w_wdata   = scale_sat(32'(fft_mag), SHIFT);
    assign w_vs_edge = out_vsync & ~r_vs;
    // A frame completing on the vsync edge is taken by that same swap.
    assign w_swap    = w_vs_edge & (r_pending | w_complete);

    // r_wr_idx is always 0 in IDLE, so the first sample lands at index 0.
    always_comb begin
        w_state_n  = r_state;
        w_idx_n    = r_wr_idx;
        w_we       = 1'b0;
        w_complete = 1'b0;
        w_short    = 1'b0;
        w_drop     = 1'b0;
        case (r_state)
            IDLE: if (fft_valid) begin
                if (r_pending) begin
                    w_drop    = 1'b1;
                    w_state_n = fft_last ? IDLE : DROP;
                end else begin
                    w_we      = 1'b1;
                    w_idx_n   = fft_last ? 9'd0 : 9'd1;
                    w_state_n = fft_last ? IDLE : FILL;
                    w_short   = fft_last;
                end
            end
            FILL: if (fft_valid) begin
                w_we    = r_wr_idx < NPTS;
                w_idx_n = w_we ? r_wr_idx + 9'd1 : r_wr_idx;
                if (fft_last) begin
                    w_idx_n    = 9'd0;
                    w_state_n  = IDLE;
                    w_complete = r_wr_idx >= LAST_IDX;
                    w_short    = r_wr_idx < LAST_IDX;
                end
            end
            DROP: w_state_n = (fft_valid && fft_last) ? IDLE : DROP;
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_wr_idx  <= 9'd0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b1;
            r_pending <= 1'b0;
            r_vs      <= 1'b0;
            r_drop    <= 1'b0;
            r_short   <= 1'b0;
            r_rd_ptr  <= 8'd0;
        end else begin
            r_state   <= w_state_n;
            r_wr_idx  <= w_idx_n;
            r_vs      <= out_vsync;
            r_drop    <= w_drop;
            r_short   <= w_short;
            r_pending <= w_swap ? 1'b0 : (r_pending | w_complete);
            if (w_swap) begin
                r_rd_bank <= r_wr_bank;
                r_wr_bank <= ~r_wr_bank;
            end
            r_rd_ptr  <= w_vs_edge ? 8'd0 :
                         fft_point_done ? ((r_rd_ptr == LAST_PTR) ? 8'd0 : r_rd_ptr + 8'd1) : r_rd_ptr;
        end
    end

    spectrum_dpram #(.DEPTH(2 * POINTS), .AW(AW + 1)) u_ram (
        .clk  (clk),
        .rst  (rst),
        .we   (w_we),
        .waddr({r_wr_bank, r_wr_idx[AW-1:0]}),
        .wdata(w_wdata),
        .re   (data_req),
        .raddr({r_rd_bank, r_rd_ptr[AW-1:0]}),
        .rdata(fft_data)
    );

    assign fft_point_cnt = r_rd_ptr;
    assign frame_pending = r_pending;
    assign frame_drop    = r_drop;
    assign short_err     = r_short;
endmodule

// File: tb/tb_fft_spectrum_buf.sv
// tb_fft_spectrum_buf: randomized bench for fft_spectrum_buf against a frame-level model
// (input frames, one pending frame, one shown frame).
module tb_fft_spectrum_buf;
    logic        clk = 0, rst = 1;
    logic        fft_valid = 0, fft_last = 0, data_req = 0, fft_point_done = 0, out_vsync = 0;
    logic [15:0] fft_mag = 0;
    logic [7:0]  fft_point_cnt, fft_data;
    logic        frame_pending, frame_drop, short_err;

    always #5 clk = ~clk;

    fft_spectrum_buf dut (
        .clk(clk), .rst(rst), .fft_valid(fft_valid), .fft_last(fft_last), .fft_mag(fft_mag),
        .data_req(data_req), .fft_point_done(fft_point_done), .out_vsync(out_vsync),
        .fft_point_cnt(fft_point_cnt), .fft_data(fft_data), .frame_pending(frame_pending),
        .frame_drop(frame_drop), .short_err(short_err)
    );

    int checks = 0, errors = 0, drops_seen = 0, shorts_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    int  shown[256], pend[256], cur[$];
    int  mode, rd_ptr, exp_data;
    bit  pending, shown_ok, data_ok, vs_prev, exp_drop, exp_short;

    function automatic int scale(input int m);
        int q = m / 256;
        return (q > 255) ? 255 : q;
    endfunction

    task automatic model_reset();
        cur.delete();
        mode = 0; pending = 0; shown_ok = 0; data_ok = 1; exp_data = 0;
        vs_prev = 0; rd_ptr = 0; exp_drop = 0; exp_short = 0;
    endtask

    task automatic step();
        bit v = fft_valid, l = fft_last, req = data_req, done = fft_point_done, vs = out_vsync;
        int mag = int'(fft_mag);
        bit edge_vs, complete;
        @(posedge clk);
        edge_vs = vs && !vs_prev;
        vs_prev = vs;
        if (req) begin
            data_ok  = shown_ok;
            exp_data = shown[rd_ptr];
        end
        exp_drop = 0; exp_short = 0; complete = 0;
        if (v) begin
            if (mode == 2) begin
                if (l) mode = 0;
            end else if (mode == 0 && pending) begin
                exp_drop = 1;
                mode = l ? 0 : 2;
            end else begin
                cur.push_back(scale(mag));
                mode = 1;
                if (l) begin
                    if (cur.size() >= 256) begin
                        for (int i = 0; i < 256; i++) pend[i] = cur[i];
                        complete = 1;
                    end else exp_short = 1;
                    cur.delete();
                    mode = 0;
                end
            end
        end
        if (edge_vs && (pending || complete)) begin
            shown = pend; shown_ok = 1; pending = 0;
        end else if (complete) pending = 1;
        if (edge_vs) rd_ptr = 0;
        else if (done) rd_ptr = (rd_ptr + 1) % 256;
        #1;
        drops_seen  += int'(frame_drop);
        shorts_seen += int'(short_err);
        check("cnt", fft_point_cnt, rd_ptr);
        check("pending", frame_pending, pending);
        check("drop", frame_drop, exp_drop);
        check("short", short_err, exp_short);
        if (data_ok) check("data", fft_data, exp_data);
    endtask

    task automatic vsync_pulse();
        out_vsync = 1; step();
        out_vsync = 0; step();
    endtask

    // kind 0: mag=k<<8; kind 1: random; kind 2: saturation corner values then random
    task automatic frame(input int len, input int kind, input bit noisy);
        for (int k = 0; k < len; k++) begin
            fft_valid = 1;
            fft_last  = (k == len - 1);
            fft_mag   = (kind == 0) ? 16'(k << 8) :
                        (kind == 2 && k == 0) ? 16'hFFFF :
                        (kind == 2 && k == 1) ? 16'h01FF :
                        (kind == 2 && k == 2) ? 16'h00FF : 16'($urandom);
            if (noisy) begin
                data_req       = ($urandom % 2) == 0;
                fft_point_done = ($urandom % 3) == 0;
                if ($urandom % 40 == 0) out_vsync = ~out_vsync;
            end
            step();
            if (noisy && $urandom % 5 == 0) begin
                fft_valid = 0; fft_last = 0;
                step();
            end
        end
        fft_valid = 0; fft_last = 0; data_req = 0; fft_point_done = 0;
    endtask

    task automatic read_bins(input int n, input bit pat);
        for (int i = 0; i < n; i++) begin
            data_req = 1; step(); data_req = 0;
            if (pat) check("bin", fft_data, i);
            fft_point_done = 1; step(); fft_point_done = 0;
        end
    endtask

    initial begin
        int lens[6] = '{1, 100, 255, 256, 257, 300};
        int d0, s0;
        model_reset();
        #12;
        check("rst_cnt", fft_point_cnt, 0);
        check("rst_data", fft_data, 0);
        check("rst_pend", frame_pending, 0);
        rst = 0;
        step();

        frame(50, 1, 0);
        rst = 1; #2;
        check("midrst_cnt", fft_point_cnt, 0);
        check("midrst_data", fft_data, 0);
        check("midrst_pend", frame_pending, 0);
        check("midrst_drop", frame_drop, 0);
        check("midrst_short", short_err, 0);
        model_reset();
        rst = 0;
        step();

        frame(256, 0, 0);
        check("full_pend", frame_pending, 1);
        vsync_pulse();
        check("swap_clr", frame_pending, 0);
        read_bins(256, 1);
        check("wrap", fft_point_cnt, 0);

        frame(256, 2, 0);
        vsync_pulse();
        data_req = 1; step(); check("sat_ffff", fft_data, 8'hFF);
        data_req = 0; fft_point_done = 1; step();
        data_req = 1; fft_point_done = 0; step(); check("sat_01ff", fft_data, 8'h01);
        data_req = 0; fft_point_done = 1; step();
        data_req = 1; fft_point_done = 0; step(); check("sat_00ff", fft_data, 8'h00);
        data_req = 0;

        frame(256, 0, 0);
        d0 = drops_seen;
        frame(256, 1, 0);
        check("drop_once", drops_seen - d0, 1);
        vsync_pulse();
        read_bins(256, 1);

        s0 = shorts_seen;
        frame(100, 1, 0);
        check("short_once", shorts_seen - s0, 1);
        check("short_nopend", frame_pending, 0);
        vsync_pulse();
        read_bins(7, 1);
        check("ptr7", fft_point_cnt, 7);
        out_vsync = 1; fft_point_done = 1; step();
        check("vs_prio", fft_point_cnt, 0);
        out_vsync = 0; fft_point_done = 0; step();

        for (int f = 0; f < 16; f++) begin
            frame(lens[$urandom % 6], 1, 1);
            repeat ($urandom % 6) begin
                data_req = $urandom % 2; fft_point_done = $urandom % 2;
                out_vsync = ($urandom % 4 == 0) ? ~out_vsync : out_vsync;
                step();
            end
            data_req = 0; fft_point_done = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fft_spectrum_buf.md
Name: fft_spectrum_buf

Overview:
- Frame buffer between the FFT magnitude stream and the LCD spectrum display stage.
- Scales and saturates each magnitude to 8 bits and stores one frame per bank in a ping-pong RAM.
- Serves the display on its fft_point_cnt / fft_data interface.
- Swaps banks only at display frame boundaries (out_vsync), so a frame is never torn on screen.

Parameters:
- POINTS, 256, bins per frame; max 256 because fft_point_cnt is 8 bits.
- MAG_W, 16, width of the input magnitude.
- SHIFT, 8, right shift applied to the magnitude before saturation.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, asynchronous, active-high.
- fft_valid  in  1  magnitude sample valid.
- fft_last  in  1  last sample of an FFT frame; qualified by fft_valid.
- fft_mag  in  MAG_W  magnitude sample, unsigned.
- data_req  in  1  display requests the current bin's amplitude.
- fft_point_done  in  1  display has finished drawing the current bin.
- out_vsync  in  1  display frame-boundary marker, level.
- fft_point_cnt  out  8  current bin index presented to the display.
- fft_data  out  8  scaled amplitude of bin fft_point_cnt.
- frame_pending  out  1  a complete frame is waiting for a bank swap.
- frame_drop  out  1  one-cycle pulse when an input frame is discarded.
- short_err  out  1  one-cycle pulse when fft_last arrives with fewer than POINTS samples.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high. All display-side inputs are synchronous to clk.
- Reset values:
  - fft_point_cnt=0, fft_data=0, frame_pending=0, frame_drop=0, short_err=0.
  - Bank selects: wr_bank=0, rd_bank=1.
  - wr_idx=0; write FSM in IDLE.
  - RAM contents are not reset.
- Scaling: q = fft_mag >> SHIFT. Stored value = 8'hFF if q > 255, otherwise q[7:0].
- Write FSM states:
  - IDLE: on fft_valid with frame_pending=0, write the sample at index 0, set wr_idx=1, go to FILL. On fft_valid with frame_pending=1, go to DROP (or stay in IDLE if fft_last is also set) and pulse frame_drop.
  - FILL: each fft_valid writes ram[wr_bank][wr_idx] and increments wr_idx. Samples with wr_idx >= POINTS are ignored; no wrap.
    - fft_last with total count >= POINTS: set frame_pending=1, wr_idx=0, go to IDLE.
    - fft_last with count < POINTS: pulse short_err, frame discarded, frame_pending unchanged, wr_idx=0, go to IDLE.
  - DROP: ignore samples until fft_valid&fft_last, then go to IDLE. A bank swap during DROP does not end DROP; discarding is frame-aligned.
  - A single-sample frame (fft_valid&fft_last in IDLE, not pending) follows the short_err rule.
- Bank swap:
  - out_vsync is registered; swap happens on its rising edge.
  - If frame_pending=1: rd_bank<=wr_bank, wr_bank<=~wr_bank, frame_pending<=0.
  - If a frame completes in the same cycle as the vsync edge, the completion is seen first and the swap takes it.
  - If frame_pending=0 on the edge, banks are unchanged and the display repeats the old frame.
- Read side:
  - rd_ptr drives fft_point_cnt.
  - On data_req, fft_data <= ram[rd_bank][rd_ptr], registered; the value is valid the cycle after data_req.
  - fft_data holds its value when data_req is low.
  - On fft_point_done, rd_ptr increments, wrapping from POINTS-1 to 0.
  - A vsync rising edge forces rd_ptr=0 and has priority over fft_point_done in the same cycle.
- Reset asserted mid-frame abandons the partial frame; banks return to their reset selection.

Decomposition:
- Package fft_buf_pkg holds:
  - POINTS, MAG_W, SHIFT defaults.
  - Write-FSM state encoding: IDLE, FILL, DROP.
  - Saturate/scale function.
- One sub-module, spectrum_dpram: simple dual-port RAM, 2*POINTS x 8.
  - Write port addressed {wr_bank, wr_idx}.
  - Registered read port addressed {rd_bank, rd_ptr}.
  - Inferred block RAM.

Test Plan:
- Reset mid-FILL -> all outputs 0, rd_bank=1; a fresh 256-sample frame then completes normally.
- Frame of 256 samples, fft_mag=i<<8 -> frame_pending=1. After the vsync edge, data_req at each bin reads fft_data=i, with fft_point_cnt stepping 0..255 on fft_point_done.
- Saturation: fft_mag=16'hFFFF -> 8'hFF; fft_mag=16'h01FF -> 8'h01; fft_mag=16'h00FF -> 8'h00.
- Two full frames with no vsync between -> second frame gives frame_drop pulse=1 and DROP until its fft_last. Display shows the first frame after vsync.
- fft_last on sample 100 -> short_err pulse, frame_pending stays 0, vsync edge causes no swap.
- rd_ptr=255 with fft_point_done -> fft_point_cnt=0. Vsync edge together with fft_point_done at rd_ptr=7 -> rd_ptr=0.
